// File: rtl/ex_pipe_unit_pkg.sv
// ex_pipe_unit_pkg: shared constants for the integer execution pipeline.
// This file holds the ALU opcode encodings and the default data and tag widths.
// It also holds a helper that sizes the shift-amount field.
package ex_pipe_unit_pkg;

    // Opcode field width and default datapath / rename-tag widths
    localparam int ALU_OP_WIDTH = 4;
    localparam int DATA_LEN     = 32;
    localparam int RRF_SEL      = 6;

    // ALU opcode encodings; 10..15 are unused and yield zero
    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_AND  = 2;
    localparam int unsigned ALU_OR   = 3;
    localparam int unsigned ALU_XOR  = 4;
    localparam int unsigned ALU_SLL  = 5;
    localparam int unsigned ALU_SRL  = 6;
    localparam int unsigned ALU_SRA  = 7;
    localparam int unsigned ALU_SLT  = 8;
    localparam int unsigned ALU_SLTU = 9;

    // Number of low src2 bits used as the shift amount
    function automatic int shamt_width(input int data_w);
        return $clog2(data_w);
    endfunction

endpackage

// File: rtl/ex_pipe_unit_if.sv
// ex_pipe_unit_if: issue-side and writeback-side signals of the execution pipe.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high. The producer holds its payload stable while
// valid is high and ready is low. issue_ready_o depends combinationally on
// wb_ready_i. kill_i is sampled every cycle and has no handshake.
interface ex_pipe_unit_if
    import ex_pipe_unit_pkg::*;
#(
    parameter int DATA_W = DATA_LEN,
    parameter int TAG_W  = RRF_SEL,
    parameter int OP_W   = ALU_OP_WIDTH
);
    // Issue side (reservation station -> pipe)
    logic              issue_valid_i;
    logic              issue_ready_o;
    logic [OP_W-1:0]   alu_op_i;
    logic [DATA_W-1:0] src1_i;
    logic [DATA_W-1:0] src2_i;
    logic [TAG_W-1:0]  rrf_tag_i;
    logic              if_write_rrf_i;
    logic              kill_i;

    // Writeback side (pipe -> writeback/ROB)
    logic              out_valid_o;
    logic              wb_ready_i;
    logic [DATA_W-1:0] result_o;
    logic [TAG_W-1:0]  rrf_tag_o;
    logic              rob_we_o;
    logic              rrf_we_o;

    // Environment view: drives issue payload and writeback ready
    modport master (
        output issue_valid_i, alu_op_i, src1_i, src2_i, rrf_tag_i,
               if_write_rrf_i, kill_i, wb_ready_i,
        input  issue_ready_o, out_valid_o, result_o, rrf_tag_o,
               rob_we_o, rrf_we_o
    );

    // Pipe view
    modport slave (
        input  issue_valid_i, alu_op_i, src1_i, src2_i, rrf_tag_i,
               if_write_rrf_i, kill_i, wb_ready_i,
        output issue_ready_o, out_valid_o, result_o, rrf_tag_o,
               rob_we_o, rrf_we_o
    );
endinterface

// File: rtl/ex_pipe_unit_alu_core.sv
// alu_core: purely combinational opcode-to-result function.
// Arithmetic wraps modulo 2^DATA_W. Shifts use the low log2(DATA_W) bits of src2.
// SLT and SLTU return 0 or 1, zero-extended to DATA_W bits.
module alu_core
    import ex_pipe_unit_pkg::*;
#(
    parameter int DATA_W = DATA_LEN,
    parameter int OP_W   = ALU_OP_WIDTH
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic [DATA_W-1:0] result
);
    localparam int SH_W = shamt_width(DATA_W);

    logic [SH_W-1:0] shamt;
    logic [31:0]     op_ext;

    assign shamt  = src2[SH_W-1:0];
    assign op_ext = 32'(op);

    // Select the result for the current opcode; unknown opcodes give zero
    always_comb begin
        result = '0;
        case (op_ext)
            ALU_ADD:  result = src1 + src2;
            ALU_SUB:  result = src1 - src2;
            ALU_AND:  result = src1 & src2;
            ALU_OR:   result = src1 | src2;
            ALU_XOR:  result = src1 ^ src2;
            ALU_SLL:  result = src1 << shamt;
            ALU_SRL:  result = src1 >> shamt;
            ALU_SRA:  result = $signed(src1) >>> shamt;
            ALU_SLT:  result = DATA_W'($signed(src1) < $signed(src2));
            ALU_SLTU: result = DATA_W'(src1 < src2);
            default:  result = '0;
        endcase
    end
endmodule

// File: rtl/ex_pipe_unit.sv
// ex_pipe_unit: LAT-deep integer execution pipeline with valid/ready output.
// The ALU result is computed at issue and captured into stage 0. Later stages
// copy {valid, result, tag, wr} forward. Empty stages let the stages behind them
// move up, and a stalled stage holds all of its fields.
// Optional feature macro: EX_KILL_EN. When it is defined, kill_i squashes every
// in-flight op at the next edge and blocks issue for that cycle.
module ex_pipe_unit
    import ex_pipe_unit_pkg::*;
#(
    parameter int DATA_W = DATA_LEN,
    parameter int TAG_W  = RRF_SEL,
    parameter int OP_W   = ALU_OP_WIDTH,
    parameter int LAT    = 2
) (
    input  logic           clk_i,
    input  logic           reset_n_i,
    ex_pipe_unit_if.slave  bus
);
    // Stage storage; index LAT-1 is the output stage
    logic [LAT-1:0]    v_q;
    logic [LAT-1:0]    wr_q;
    logic [DATA_W-1:0] res_q [LAT];
    logic [TAG_W-1:0]  tag_q [LAT];

    logic [LAT-1:0]    stage_open;
    logic [DATA_W-1:0] alu_result;
    logic              kill;
    logic              issue_ready;
    logic              accept;

    alu_core #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu_core (
        .op     (bus.alu_op_i),
        .src1   (bus.src1_i),
        .src2   (bus.src2_i),
        .result (alu_result)
    );

`ifdef EX_KILL_EN
    assign kill = bus.kill_i;
`else
    assign kill = 1'b0;
`endif

    // A stage may load when writeback drains the tail, or when any stage
    // from itself to the tail is empty (the gap lets everything behind move up)
    always_comb begin
        stage_open = '0;
        for (int k = 0; k < LAT; k++) begin
            stage_open[k] = bus.wb_ready_i;
            for (int j = k; j < LAT; j++) begin
                if (!v_q[j]) begin
                    stage_open[k] = 1'b1;
                end
            end
        end
    end

    assign issue_ready = stage_open[0] & ~kill;
    assign accept      = bus.issue_valid_i & issue_ready;

    // Advance, collapse bubbles, or hold each stage; kill drops all valid bits
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q  <= '0;
            wr_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                res_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            if (stage_open[0]) begin
                v_q[0] <= accept;
                if (accept) begin
                    res_q[0] <= alu_result;
                    tag_q[0] <= bus.rrf_tag_i;
                    wr_q[0]  <= bus.if_write_rrf_i;
                end
            end
            for (int k = 1; k < LAT; k++) begin
                if (stage_open[k]) begin
                    v_q[k] <= v_q[k-1];
                    if (v_q[k-1]) begin
                        res_q[k] <= res_q[k-1];
                        tag_q[k] <= tag_q[k-1];
                        wr_q[k]  <= wr_q[k-1];
                    end
                end
            end
            if (kill) begin
                v_q <= '0;
            end
        end
    end

    assign bus.issue_ready_o = issue_ready;
    assign bus.out_valid_o   = v_q[LAT-1];
    assign bus.result_o      = res_q[LAT-1];
    assign bus.rrf_tag_o     = tag_q[LAT-1];
    assign bus.rob_we_o      = v_q[LAT-1];
    assign bus.rrf_we_o      = v_q[LAT-1] & wr_q[LAT-1];
endmodule

// File: tb/tb_ex_pipe_unit.sv
// tb_ex_pipe_unit: directed table-driven bench for ex_pipe_unit (LAT=2).
module tb_ex_pipe_unit;
    import ex_pipe_unit_pkg::*;

    localparam int DW  = 32;
    localparam int TW  = 6;
    localparam int OW  = 4;
    localparam int LAT = 2;
    localparam int W   = DW + TW + 1;
    localparam int NV  = 18;

    typedef struct {
        logic [OW-1:0] op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [TW-1:0] tag;
        logic          wr;
        logic [DW-1:0] exp;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_pipe_unit_if #(.DATA_W(DW), .TAG_W(TW), .OP_W(OW)) bus ();

    ex_pipe_unit #(
        .DATA_W (DW),
        .TAG_W  (TW),
        .OP_W   (OW),
        .LAT    (LAT)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus.slave)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_fires = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur_exp = '0;
    logic [W-1:0] sb_e;
    vec_t        vecs [NV];
    vec_t        bp [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input int tag, input logic wr, input logic [DW-1:0] exp);
        vec_t v;
        v.op  = OW'(op);
        v.a   = a;
        v.b   = b;
        v.tag = TW'(tag);
        v.wr  = wr;
        v.exp = exp;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input vec_t v);
        bus.issue_valid_i  = 1'b1;
        bus.alu_op_i       = v.op;
        bus.src1_i         = v.a;
        bus.src2_i         = v.b;
        bus.rrf_tag_i      = v.tag;
        bus.if_write_rrf_i = v.wr;
        cur_exp            = {v.tag, v.wr, v.exp};
    endtask

    task automatic idle();
        bus.issue_valid_i  = 1'b0;
        bus.alu_op_i       = '0;
        bus.src1_i         = '0;
        bus.src2_i         = '0;
        bus.rrf_tag_i      = '0;
        bus.if_write_rrf_i = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) begin
            next_cycle();
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- scoreboard ----------------
    // Pops on every fire and pushes on every accepted issue, at the negedge
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid_o && bus.wb_ready_i) begin
                n_fires++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected_fire: got %h expected no output",
                             {bus.rrf_tag_o, bus.rrf_we_o, bus.result_o});
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_order", 64'({bus.rrf_tag_o, bus.rrf_we_o, bus.result_o}), 64'(sb_e));
                end
            end
            if (bus.issue_valid_i && bus.issue_ready_o) begin
                exp_q.push_back(cur_exp);
            end
        end
    end

    // Hard time limit so the run always reaches its summary line
    initial begin
        #200000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int j;
        int f0;

        vecs[0]  = mk(0,  32'd5,         32'd7,         3,  1'b1, 32'd12);
        vecs[1]  = mk(1,  32'h8000_0000, 32'd1,         1,  1'b1, 32'h7FFF_FFFF);
        vecs[2]  = mk(2,  32'h8000_0000, 32'd1,         2,  1'b0, 32'h0000_0000);
        vecs[3]  = mk(3,  32'h8000_0000, 32'd1,         4,  1'b1, 32'h8000_0001);
        vecs[4]  = mk(4,  32'h8000_0000, 32'd1,         5,  1'b1, 32'h8000_0001);
        vecs[5]  = mk(5,  32'h8000_0000, 32'd1,         6,  1'b0, 32'h0000_0000);
        vecs[6]  = mk(6,  32'h8000_0000, 32'd1,         7,  1'b1, 32'h4000_0000);
        vecs[7]  = mk(7,  32'h8000_0000, 32'd1,         8,  1'b1, 32'hC000_0000);
        vecs[8]  = mk(8,  32'h8000_0000, 32'd1,         9,  1'b1, 32'd1);
        vecs[9]  = mk(9,  32'h8000_0000, 32'd1,         10, 1'b1, 32'd0);
        vecs[10] = mk(12, 32'h8000_0000, 32'd1,         11, 1'b1, 32'd0);
        vecs[11] = mk(0,  32'hFFFF_FFFF, 32'd1,         63, 1'b1, 32'd0);
        vecs[12] = mk(1,  32'd3,         32'd5,         0,  1'b1, 32'hFFFF_FFFE);
        vecs[13] = mk(5,  32'd1,         32'd33,        12, 1'b0, 32'd2);
        vecs[14] = mk(7,  32'h8000_0000, 32'd31,        13, 1'b1, 32'hFFFF_FFFF);
        vecs[15] = mk(15, 32'd5,         32'd7,         14, 1'b1, 32'd0);
        vecs[16] = mk(8,  32'd5,         32'hFFFF_FFFF, 15, 1'b1, 32'd0);
        vecs[17] = mk(9,  32'd1,         32'd2,         16, 1'b0, 32'd1);

        bp[0] = mk(0, 32'd1,    32'd2,    10, 1'b1, 32'd3);
        bp[1] = mk(1, 32'd10,   32'd3,    11, 1'b0, 32'd7);
        bp[2] = mk(4, 32'hFF,   32'h0F,   12, 1'b1, 32'hF0);
        bp[3] = mk(5, 32'd1,    32'd4,    13, 1'b1, 32'd16);

        // Reset and post-reset output values
        idle();
        bus.kill_i     = 1'b0;
        bus.wb_ready_i = 1'b1;
        rst_n          = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("rst_issue_ready", 64'(bus.issue_ready_o), 64'd1);
        check("rst_out_valid",   64'(bus.out_valid_o),   64'd0);
        check("rst_result",      64'(bus.result_o),      64'd0);
        check("rst_tag",         64'(bus.rrf_tag_o),     64'd0);
        check("rst_rrf_we",      64'(bus.rrf_we_o),      64'd0);
        check("rst_rob_we",      64'(bus.rob_we_o),      64'd0);
        next_cycle();

        // Single op: ADD 5+7 issued in cycle 0, visible in cycle 2, gone in cycle 3
        drive(vecs[0]);
        @(negedge clk);
        check("single_c0_ready", 64'(bus.issue_ready_o), 64'd1);
        next_cycle();
        idle();
        @(negedge clk);
        check("single_c1_valid", 64'(bus.out_valid_o), 64'd0);
        next_cycle();
        @(negedge clk);
        check("single_c2_valid",  64'(bus.out_valid_o), 64'd1);
        check("single_c2_result", 64'(bus.result_o),    64'd12);
        check("single_c2_tag",    64'(bus.rrf_tag_o),   64'd3);
        check("single_c2_rrf_we", 64'(bus.rrf_we_o),    64'd1);
        check("single_c2_rob_we", 64'(bus.rob_we_o),    64'd1);
        next_cycle();
        @(negedge clk);
        check("single_c3_valid", 64'(bus.out_valid_o), 64'd0);
        next_cycle();

        // Table: back-to-back issue, each result exactly LAT cycles later
        for (int i = 0; i < NV + LAT; i++) begin
            if (i < NV) drive(vecs[i]);
            else        idle();
            @(negedge clk);
            check($sformatf("tbl_ready_%0d", i), 64'(bus.issue_ready_o), 64'd1);
            if (i >= LAT) begin
                check($sformatf("tbl_valid_%0d", i - LAT),  64'(bus.out_valid_o), 64'd1);
                check($sformatf("tbl_result_%0d", i - LAT), 64'(bus.result_o),    64'(vecs[i-LAT].exp));
                check($sformatf("tbl_tag_%0d", i - LAT),    64'(bus.rrf_tag_o),   64'(vecs[i-LAT].tag));
                check($sformatf("tbl_rrf_we_%0d", i - LAT), 64'(bus.rrf_we_o),    64'(vecs[i-LAT].wr));
            end else begin
                check($sformatf("tbl_empty_%0d", i), 64'(bus.out_valid_o), 64'd0);
            end
            next_cycle();
        end
        idle();
        @(negedge clk);
        check("tbl_drained", 64'(bus.out_valid_o), 64'd0);
        next_cycle();

        // Back-pressure: 4 ops offered with writeback stalled, then released
        bus.wb_ready_i = 1'b0;
        j = 0;
        for (int c = 0; c < 4; c++) begin
            drive(bp[j]);
            @(negedge clk);
            check($sformatf("bp_ready_c%0d", c), 64'(bus.issue_ready_o), (c < 2) ? 64'd1 : 64'd0);
            if (bus.issue_ready_o) j++;
            next_cycle();
        end
        check("bp_accepted", 64'(j), 64'd2);
        check("bp_hold_valid", 64'(bus.out_valid_o), 64'd1);
        check("bp_hold_result", 64'(bus.result_o), 64'd3);
        bus.wb_ready_i = 1'b1;
        f0 = n_fires;
        for (int t = 0; t < 12 && (j < 4 || exp_q.size() > 0); t++) begin
            if (j < 4) drive(bp[j]);
            else       idle();
            @(negedge clk);
            if (t == 0) check("bp_full_fire_and_issue", 64'(bus.issue_ready_o), 64'd1);
            if (bus.issue_valid_i && bus.issue_ready_o) j++;
            next_cycle();
        end
        idle();
        check("bp_fire_count", 64'(n_fires - f0), 64'd4);
        check("bp_sb_empty", 64'(exp_q.size()), 64'd0);

        // Bubble collapse: A, gap, B with writeback stalled; then A, B on consecutive fires
        bus.wb_ready_i = 1'b0;
        drive(mk(3, 32'hA0, 32'h0A, 30, 1'b1, 32'hAA));
        next_cycle();
        idle();
        next_cycle();
        drive(mk(0, 32'hB0, 32'h0B, 31, 1'b0, 32'hBB));
        @(negedge clk);
        check("bub_b_ready", 64'(bus.issue_ready_o), 64'd1);
        next_cycle();
        idle();
        @(negedge clk);
        check("bub_full_ready",  64'(bus.issue_ready_o), 64'd0);
        check("bub_hold_result", 64'(bus.result_o),      64'hAA);
        next_cycle();
        bus.wb_ready_i = 1'b1;
        @(negedge clk);
        check("bub_fire_a_valid",  64'(bus.out_valid_o), 64'd1);
        check("bub_fire_a_result", 64'(bus.result_o),    64'hAA);
        next_cycle();
        @(negedge clk);
        check("bub_fire_b_valid",  64'(bus.out_valid_o), 64'd1);
        check("bub_fire_b_result", 64'(bus.result_o),    64'hBB);
        check("bub_fire_b_rrf_we", 64'(bus.rrf_we_o),    64'd0);
        next_cycle();
        @(negedge clk);
        check("bub_empty", 64'(bus.out_valid_o), 64'd0);
        next_cycle();

        // Kill pulse with two ops in flight
        bus.wb_ready_i = 1'b0;
        drive(mk(2, 32'hF0F0, 32'hFF00, 20, 1'b1, 32'hF000));
        next_cycle();
        drive(mk(3, 32'h1, 32'h2, 21, 1'b0, 32'h3));
        next_cycle();
`ifdef EX_KILL_EN
        drive(mk(6, 32'h100, 32'd4, 22, 1'b1, 32'h10));
        bus.kill_i = 1'b1;
        @(negedge clk);
        check("kill_ready",     64'(bus.issue_ready_o), 64'd0);
        check("kill_out_valid", 64'(bus.out_valid_o),   64'd1);
        next_cycle();
        bus.kill_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("kill_after_valid", 64'(bus.out_valid_o),   64'd0);
        check("kill_after_ready", 64'(bus.issue_ready_o), 64'd1);
        next_cycle();
        idle();
        bus.wb_ready_i = 1'b1;
        f0 = n_fires;
        drain("kill_drain");
        check("kill_fire_count", 64'(n_fires - f0), 64'd1);
`else
        idle();
        bus.kill_i = 1'b1;
        @(negedge clk);
        check("nokill_ready", 64'(bus.issue_ready_o), 64'd0);
        next_cycle();
        bus.kill_i = 1'b0;
        @(negedge clk);
        check("nokill_valid_kept", 64'(bus.out_valid_o), 64'd1);
        check("nokill_result",     64'(bus.result_o),    64'hF000);
        next_cycle();
        bus.wb_ready_i = 1'b1;
        f0 = n_fires;
        drain("nokill_drain");
        check("nokill_fire_count", 64'(n_fires - f0), 64'd2);
`endif

        // Asynchronous reset between edges while ops are in flight
        bus.wb_ready_i = 1'b1;
        drive(mk(0, 32'h11, 32'h22, 40, 1'b1, 32'h33));
        next_cycle();
        drive(mk(0, 32'h44, 32'h11, 41, 1'b1, 32'h55));
        @(posedge clk);
        idle();
        #2;
        check("arst_pre_valid", 64'(bus.out_valid_o), 64'd1);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_out_valid", 64'(bus.out_valid_o),   64'd0);
        check("arst_result",    64'(bus.result_o),      64'd0);
        check("arst_tag",       64'(bus.rrf_tag_o),     64'd0);
        check("arst_rrf_we",    64'(bus.rrf_we_o),      64'd0);
        check("arst_rob_we",    64'(bus.rob_we_o),      64'd0);
        #10 rst_n = 1'b1;
        @(negedge clk);
        check("arst_release_ready", 64'(bus.issue_ready_o), 64'd1);
        check("arst_release_valid", 64'(bus.out_valid_o),   64'd0);
        next_cycle();
        drive(mk(0, 32'd100, 32'd23, 42, 1'b1, 32'd123));
        next_cycle();
        idle();
        drain("arst_post_drain");

        check("final_sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
